// File: rtl/load_unit_if.sv
// load_unit_if: issue, memory and write-back signals of the load unit.
interface load_unit_if;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [31:0] addr_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;
    logic        busy_o;
    modport slave (
        input  ld_valid_i, addr_i, funct3_i, rd_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output ld_ready_o, mem_req_o, mem_addr_o, wb_valid_o, wb_rd_o, wb_data_o, err_o, busy_o
    );
    modport master (
        output ld_valid_i, addr_i, funct3_i, rd_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  ld_ready_o, mem_req_o, mem_addr_o, wb_valid_o, wb_rd_o, wb_data_o, err_o, busy_o
    );
endinterface

// File: rtl/load_unit.sv
// load_unit: multi-cycle RISC-V load path (req/gnt/rvalid fetch, lane extract, sign/zero extend).
// Optional LOAD_MISALIGN_CHECK_EN: misaligned LH/LHU/LW error out without a memory access.
module load_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic       clk,
    input logic       rst_n,
    load_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane;
    logic [2:0]       f3;
    logic [4:0]       rd;
    function automatic logic [31:0] fmt(logic [31:0] w, logic [1:0] a, logic [2:0] f);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {a, 3'b000});
        h = a[1] ? w[31:16] : w[15:0];
        return f == 3'b000 ? {{24{b[7]}}, b} :
               f == 3'b100 ? {24'b0, b} :
               f == 3'b001 ? {{16{h[15]}}, h} :
               f == 3'b101 ? {16'b0, h} : w;
    endfunction
    // Reserved encodings still fetch a full word but flag an error.
    function automatic logic bad_f3(logic [2:0] f);
        return f == 3'b011 || f[2:1] == 2'b11;
    endfunction
`ifdef LOAD_MISALIGN_CHECK_EN
    logic misalign;
    assign misalign = ((bus.funct3_i == 3'b001 || bus.funct3_i == 3'b101) && bus.addr_i[0]) ||
                      (bus.funct3_i == 3'b010 && bus.addr_i[1:0] != 2'b00);
`endif
    assign bus.ld_ready_o = state == IDLE;
    assign bus.busy_o     = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            lane           <= '0;
            f3             <= '0;
            rd             <= '0;
            bus.mem_req_o  <= 1'b0;
            bus.mem_addr_o <= '0;
            bus.wb_valid_o <= 1'b0;
            bus.wb_rd_o    <= '0;
            bus.wb_data_o  <= '0;
            bus.err_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.ld_valid_i) begin
                    lane           <= bus.addr_i[1:0];
                    f3             <= bus.funct3_i;
                    rd             <= bus.rd_i;
                    bus.mem_addr_o <= {bus.addr_i[31:2], 2'b00};
`ifdef LOAD_MISALIGN_CHECK_EN
                    if (misalign) begin
                        state          <= DONE;
                        bus.wb_valid_o <= 1'b1;
                        bus.wb_rd_o    <= bus.rd_i;
                        bus.wb_data_o  <= '0;
                        bus.err_o      <= 1'b1;
                    end else
`endif
                    begin
                        state         <= REQ;
                        bus.mem_req_o <= 1'b1;
                    end
                end
                REQ: if (bus.mem_gnt_i) begin
                    state         <= WAIT;
                    bus.mem_req_o <= 1'b0;
                    cnt           <= '0;
                end
                // rvalid is tested first so it wins over a coincident timeout.
                WAIT: if (bus.mem_rvalid_i) begin
                    state          <= DONE;
                    bus.wb_valid_o <= 1'b1;
                    bus.wb_rd_o    <= rd;
                    bus.wb_data_o  <= fmt(bus.mem_rdata_i, lane, f3);
                    bus.err_o      <= bad_f3(f3);
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state          <= DONE;
                    bus.wb_valid_o <= 1'b1;
                    bus.wb_rd_o    <= rd;
                    bus.wb_data_o  <= '0;
                    bus.err_o      <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    state          <= IDLE;
                    bus.wb_valid_o <= 1'b0;
                    bus.err_o      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed and random loads checked against an arithmetic reference model.
module tb_load_unit;
    localparam int TIMEOUT = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    load_unit_if bus();
    load_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] ref_data(logic [31:0] w, logic [1:0] a, logic [2:0] f);
        longint b, h;
        b = (longint'(w) >> (8 * a)) % 256;
        h = (longint'(w) >> (16 * a[1])) % 65536;
        case (f)
            3'b000:  return 32'(b >= 128 ? b - 256 : b);
            3'b100:  return 32'(b);
            3'b001:  return 32'(h >= 32768 ? h - 65536 : h);
            3'b101:  return 32'(h);
            default: return w;
        endcase
    endfunction
    function automatic logic ref_err(logic [2:0] f);
        return !(f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    endfunction
    function automatic logic ref_mis(logic [31:0] a, logic [2:0] f);
`ifdef LOAD_MISALIGN_CHECK_EN
        return ((f == 3'b001 || f == 3'b101) && a[0]) || (f == 3'b010 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction
    // rvc: WAIT cycle (1-based) carrying rvalid; 0 means never (timeout).
    task automatic run_load(input logic [31:0] addr, input logic [2:0] f, input logic [4:0] rd,
                            input int gdly, input int rvc, input logic [31:0] rdata);
        logic got;
        check("ready_idle", bus.ld_ready_o, 1'b1);
        bus.ld_valid_i = 1'b1;
        bus.addr_i     = addr;
        bus.funct3_i   = f;
        bus.rd_i       = rd;
        step();
        bus.ld_valid_i = 1'b0;
        bus.addr_i     = $urandom;
        bus.funct3_i   = 3'($urandom);
        bus.rd_i       = 5'($urandom);
        if (ref_mis(addr, f)) begin
            check("mis_valid", bus.wb_valid_o, 1'b1);
            check("mis_err", bus.err_o, 1'b1);
            check("mis_data", bus.wb_data_o, 32'h0);
            check("mis_rd", bus.wb_rd_o, rd);
            check("mis_req", bus.mem_req_o, 1'b0);
            step();
            check("mis_valid_end", bus.wb_valid_o, 1'b0);
            check("mis_ready", bus.ld_ready_o, 1'b1);
            return;
        end
        for (int g = 0; g <= gdly; g++) begin
            check("req_high", bus.mem_req_o, 1'b1);
            check("req_addr", bus.mem_addr_o, addr & 32'hFFFF_FFFC);
            check("req_ready", bus.ld_ready_o, 1'b0);
            bus.mem_gnt_i    = (g == gdly);
            bus.mem_rvalid_i = 1'($urandom);
            step();
        end
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        got = 1'b0;
        for (int w = 1; w <= TIMEOUT; w++) begin
            check("wait_req", bus.mem_req_o, 1'b0);
            check("wait_wb", bus.wb_valid_o, 1'b0);
            check("wait_busy", bus.busy_o, 1'b1);
            bus.mem_rvalid_i = (w == rvc);
            bus.mem_rdata_i  = (w == rvc) ? rdata : $urandom;
            step();
            bus.mem_rvalid_i = 1'b0;
            if (w == rvc) begin
                got = 1'b1;
                break;
            end
        end
        check("done_valid", bus.wb_valid_o, 1'b1);
        check("done_rd", bus.wb_rd_o, rd);
        check("done_data", bus.wb_data_o, got ? ref_data(rdata, addr[1:0], f) : 32'h0);
        check("done_err", bus.err_o, got ? ref_err(f) : 1'b1);
        check("done_ready", bus.ld_ready_o, 1'b0);
        step();
        check("post_valid", bus.wb_valid_o, 1'b0);
        check("post_err", bus.err_o, 1'b0);
        check("post_ready", bus.ld_ready_o, 1'b1);
    endtask
    initial begin
        bus.ld_valid_i   = 1'b0;
        bus.addr_i       = '0;
        bus.funct3_i     = '0;
        bus.rd_i         = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        step();
        check("rst_req", bus.mem_req_o, 1'b0);
        check("rst_addr", bus.mem_addr_o, 32'h0);
        check("rst_wb", bus.wb_valid_o, 1'b0);
        check("rst_ready", bus.ld_ready_o, 1'b1);
        check("rst_busy", bus.busy_o, 1'b0);
        rst_n = 1'b1;
        step();
        run_load(32'h0000_1003, 3'b000, 5'd1, 0, 1, 32'h80FF_1234);
        run_load(32'h0000_1003, 3'b100, 5'd2, 0, 1, 32'h80FF_1234);
        run_load(32'h0000_2002, 3'b001, 5'd3, 0, 1, 32'h8001_7FFF);
        run_load(32'h0000_2000, 3'b101, 5'd4, 0, 1, 32'h8001_7FFF);
        run_load(32'h0000_4010, 3'b010, 5'd5, 3, 2, 32'h1234_5678);
        run_load(32'h0000_5000, 3'b010, 5'd6, 0, 0, 32'h0);
        run_load(32'h0000_5004, 3'b010, 5'd7, 1, 16, 32'hCAFE_F00D);
        run_load(32'h0000_3000, 3'b011, 5'd0, 0, 1, 32'hDEAD_BEEF);
        run_load(32'h0000_3001, 3'b010, 5'd8, 0, 1, 32'hDEAD_BEEF);
        run_load(32'h0000_3003, 3'b101, 5'd9, 0, 1, 32'hDEAD_BEEF);
        // Asynchronous reset while WAIT has rvalid pending.
        bus.ld_valid_i = 1'b1;
        bus.addr_i     = 32'h0000_6000;
        bus.funct3_i   = 3'b010;
        bus.rd_i       = 5'd10;
        step();
        bus.ld_valid_i = 1'b0;
        bus.mem_gnt_i  = 1'b1;
        step();
        bus.mem_gnt_i    = 1'b0;
        step();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hAAAA_5555;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_req", bus.mem_req_o, 1'b0);
        check("arst_addr", bus.mem_addr_o, 32'h0);
        check("arst_wb", bus.wb_valid_o, 1'b0);
        check("arst_data", bus.wb_data_o, 32'h0);
        check("arst_rd", bus.wb_rd_o, 5'd0);
        check("arst_err", bus.err_o, 1'b0);
        check("arst_ready", bus.ld_ready_o, 1'b1);
        check("arst_busy", bus.busy_o, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.mem_rvalid_i = 1'b0;
            check("arst_no_wb", bus.wb_valid_o, 1'b0);
            check("arst_idle", bus.ld_ready_o, 1'b1);
        end
        for (int i = 0; i < 60; i++) begin
            int rvc;
            rvc = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            run_load($urandom, 3'($urandom), 5'($urandom), int'($urandom_range(0, 3)), rvc, $urandom);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Multi-cycle load path of the RISC-V core; the read-side counterpart of the store-data formatting path.
- Accepts one load (address, funct3, rd) per transaction and fetches the word from data memory over a req/gnt/rvalid handshake.
- Extracts the byte, halfword or word lane and sign- or zero-extends it.
- Returns the formatted value with its rd for register-file write-back.
- Stalls the issuing side while the transaction is in flight.

Parameters:
- TIMEOUT, 16: max cycles in WAIT without mem_rvalid_i before the transaction is aborted (must be >= 2).
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_valid_i  in  1  load request from issue stage.
- ld_ready_o  out  1  unit can accept a load.
- addr_i  in  32  byte address (rs1 + imm).
- funct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- rd_i  in  5  destination register.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  32  word-aligned address, addr[31:2] followed by 2'b00.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data word.
- wb_valid_o  out  1  one-cycle write-back strobe.
- wb_rd_o  out  5  write-back register.
- wb_data_o  out  32  formatted load data.
- err_o  out  1  one-cycle error strobe, coincident with wb_valid_o.
- busy_o  out  1  transaction in flight (~ld_ready_o).

Behaviour:
- States: IDLE, REQ, WAIT, DONE; 2-bit encoding; registered.
- Reset (rst=0, asynchronous):
  - state=IDLE, timeout counter=0.
  - Outputs: mem_req_o=0, mem_addr_o=0, wb_valid_o=0, wb_rd_o=0, wb_data_o=0, err_o=0, ld_ready_o=1, busy_o=0.
  - Reset mid-transaction abandons the transaction silently; no write-back, no error.
- IDLE: ld_ready_o=1.
  - On an edge with ld_valid_i=1, latch addr[1:0], funct3 and rd; register mem_addr_o; go to REQ.
  - No other input is sampled in IDLE.
- REQ: mem_req_o=1 and mem_addr_o are held stable until the edge where mem_gnt_i=1, then go to WAIT and clear the counter.
  - mem_rvalid_i is ignored in REQ.
- WAIT: mem_req_o=0; the counter increments each cycle.
  - An edge with mem_rvalid_i=1 captures the formatted data into wb_data_o and goes to DONE.
  - If the counter reaches TIMEOUT-1 with no rvalid, go to DONE with wb_data_o=0 and an error flag set.
  - If rvalid and the timeout coincide, rvalid wins: data is captured, no error.
- DONE: wb_valid_o=1 and wb_rd_o=latched rd for exactly one cycle; err_o=error flag. Next state is IDLE.
  - ld_ready_o=0 in DONE, so back-to-back loads are separated by at least one IDLE cycle.
- Minimum latency: accept at edge T, gnt at T+1, rvalid at T+2, wb_valid_o high during cycle T+3.
- Formatting, with lane chosen by the latched addr[1:0]:
  - LB/LBU take byte addr[1:0], sign/zero-extended to 32 bits.
  - LH/LHU take halfword addr[1]; addr[0] is ignored.
  - LW takes the full word; addr[1:0] is ignored.
  - funct3 011, 110, 111 are formatted as LW with err_o=1 in DONE.
- wb_rd_o=0 is still written back; suppressing x0 writes is the register file's job.

Optional Feature:
- Macro: LOAD_MISALIGN_CHECK_EN.
- Defined: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, skips REQ/WAIT.
  - IDLE goes directly to DONE: mem_req_o is never raised, wb_data_o=0, err_o=1.
- Undefined: no check; the alignment-ignoring lane rules above apply.

Test Plan:
- Reset: assert rst=0 mid-WAIT with rvalid pending -> all outputs 0 and ld_ready_o=1 immediately; a later rvalid produces no wb_valid_o.
- LB with addr=0x1003, rdata=0x80FF_1234 -> mem_addr_o=0x1000; wb_data_o=0xFFFF_FF80, err_o=0.
  - LBU, same inputs -> wb_data_o=0x0000_0080.
- LH with addr=0x2002, rdata=0x8001_7FFF -> wb_data_o=0xFFFF_8001.
  - LHU with addr=0x2000 -> wb_data_o=0x0000_7FFF.
- Handshake: mem_gnt_i held low 3 cycles, rvalid 2 cycles after gnt -> mem_req_o high exactly 4 cycles with mem_addr_o stable; wb_valid_o single-cycle pulse with correct rd; ld_ready_o low throughout.
- Timeout: gnt given, rvalid never -> DONE after TIMEOUT=16 WAIT cycles with wb_valid_o=1, err_o=1, wb_data_o=0.
  - Repeat with rvalid on cycle 16 -> data captured, err_o=0.
- funct3=011, LW to 0x3000 with rdata=0xDEAD_BEEF -> wb_data_o=0xDEAD_BEEF, err_o=1.
  - With LOAD_MISALIGN_CHECK_EN, LW to 0x3001 -> no mem_req_o, wb_valid_o and err_o one cycle after accept.
